max_pool_multi: RTL

//  Multi-channel streaming max-pool engine; successor to the single-channel pool.

---
 rtl/max_pool_multi.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/max_pool_multi.sv
// rtl/max_pool_multi.sv - multi-channel streaming max-pool engine
// Buffers one frame, then scans each pooling window and emits one beat per output position.
module max_pool_multi #(
   parameter int DATAWIDTH        = 32,
   parameter int CHANNELS         = 4,
   parameter int MAT_DIMENSION    = 5,
   parameter int WINDOW_DIMENSION = 3,
   parameter int STRIDE           = 2,
   parameter int FLOAT_MODE       = 1,
   localparam int OUTPUT_DIMENSION = (MAT_DIMENSION - WINDOW_DIMENSION) / STRIDE + 1,
   localparam int RW               = $clog2(OUTPUT_DIMENSION + 1)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [CHANNELS*DATAWIDTH-1:0] in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [CHANNELS*DATAWIDTH-1:0] out_data,
   output logic [RW-1:0]                 out_row,
   output logic [RW-1:0]                 out_col,
   output logic                          busy,
   output logic                          finished
);

   localparam int NPIX = MAT_DIMENSION * MAT_DIMENSION;
   localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam int WW   = (WINDOW_DIMENSION > 1) ? $clog2(WINDOW_DIMENSION) : 1;
   localparam int BW   = CHANNELS * DATAWIDTH;

   localparam logic [AW-1:0] LAST_PIX = AW'(NPIX - 1);
   localparam logic [AW-1:0] COL_STEP = AW'(STRIDE);
   localparam logic [AW-1:0] ROW_STEP = AW'(MAT_DIMENSION * STRIDE);
   localparam logic [AW-1:0] WIN_WRAP = AW'(MAT_DIMENSION - WINDOW_DIMENSION + 1);
   localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW_DIMENSION - 1);
   localparam logic [RW-1:0] POS_LAST = RW'(OUTPUT_DIMENSION - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_POOL,
      S_OUT,
      S_DONE
   } state_t;

   state_t state, state_next;

   logic [BW-1:0] mem [NPIX];
   logic [AW-1:0] load_cnt;
   logic [AW-1:0] rd_addr;
   logic [AW-1:0] win_base;
   logic [AW-1:0] row_base;
   logic [WW-1:0] win_r;
   logic [WW-1:0] win_c;
   logic [RW-1:0] pos_r;
   logic [RW-1:0] pos_c;
   logic [BW-1:0] acc;
   logic [BW-1:0] acc_next;
   logic [BW-1:0] rd_word;

   logic start_ok;
   logic load_fire;
   logic win_first;
   logic win_last;
   logic out_fire;
   logic pos_last;

   // Monotonic ordering key: unsigned compare of keys matches the numeric order of the inputs.
   function automatic logic [DATAWIDTH-1:0] order_key(input logic [DATAWIDTH-1:0] x);
      if (FLOAT_MODE != 0 && x[DATAWIDTH-1]) return ~x;
      return {~x[DATAWIDTH-1], x[DATAWIDTH-2:0]};
   endfunction

   assign start_ok  = start && (state == S_IDLE || state == S_DONE);
   assign load_fire = (state == S_LOAD) && in_valid;
   assign win_first = (win_r == '0) && (win_c == '0);
   assign win_last  = (win_r == WIN_LAST) && (win_c == WIN_LAST);
   assign out_fire  = (state == S_OUT) && out_ready;
   assign pos_last  = (pos_r == POS_LAST) && (pos_c == POS_LAST);
   assign rd_word   = mem[rd_addr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (start) state_next = S_LOAD;
         S_LOAD:  if (in_valid && load_cnt == LAST_PIX) state_next = S_POOL;
         S_POOL:  if (win_last) state_next = S_OUT;
         S_OUT:   if (out_ready) state_next = pos_last ? S_DONE : S_POOL;
         S_DONE:  if (start) state_next = S_LOAD;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      finished  = 1'b0;
      case (state)
         S_LOAD: begin
            in_ready = 1'b1;
            busy     = 1'b1;
         end
         S_POOL: busy = 1'b1;
         S_OUT: begin
            out_valid = 1'b1;
            busy      = 1'b1;
         end
         S_DONE:  finished = 1'b1;
         default: ;
      endcase
   end

   // Frame buffer has no reset; it is fully rewritten before every scan.
   always_ff @(posedge clk) begin
      if (load_fire) mem[load_cnt] <= in_data;
   end

   // Strictly-greater replace keeps the earliest of equal elements.
   always_comb begin
      acc_next = acc;
      for (int k = 0; k < CHANNELS; k++) begin
         if (win_first ||
             (order_key(rd_word[k*DATAWIDTH +: DATAWIDTH]) >
              order_key(acc[k*DATAWIDTH +: DATAWIDTH])))
            acc_next[k*DATAWIDTH +: DATAWIDTH] = rd_word[k*DATAWIDTH +: DATAWIDTH];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         load_cnt <= '0;
         rd_addr  <= '0;
         win_base <= '0;
         row_base <= '0;
         win_r    <= '0;
         win_c    <= '0;
         pos_r    <= '0;
         pos_c    <= '0;
         acc      <= '0;
      end else if (start_ok) begin
         load_cnt <= '0;
         rd_addr  <= '0;
         win_base <= '0;
         row_base <= '0;
         win_r    <= '0;
         win_c    <= '0;
         pos_r    <= '0;
         pos_c    <= '0;
         acc      <= '0;
      end else begin
         if (load_fire) load_cnt <= load_cnt + AW'(1);

         if (state == S_POOL) begin
            acc <= acc_next;
            if (win_c == WIN_LAST) begin
               win_c   <= '0;
               win_r   <= (win_r == WIN_LAST) ? '0 : win_r + WW'(1);
               rd_addr <= rd_addr + WIN_WRAP;
            end else begin
               win_c   <= win_c + WW'(1);
               rd_addr <= rd_addr + AW'(1);
            end
         end

         // Next window's top-left address is derived from the previous one, never multiplied.
         if (out_fire && !pos_last) begin
            if (pos_c == POS_LAST) begin
               pos_c    <= '0;
               pos_r    <= pos_r + RW'(1);
               row_base <= row_base + ROW_STEP;
               win_base <= row_base + ROW_STEP;
               rd_addr  <= row_base + ROW_STEP;
            end else begin
               pos_c    <= pos_c + RW'(1);
               win_base <= win_base + COL_STEP;
               rd_addr  <= win_base + COL_STEP;
            end
         end
      end
   end

   assign out_data = acc;
   assign out_row  = pos_r;
   assign out_col  = pos_c;

endmodule
